rv_inst_encoder: RTL



---
 rtl/rv_inst_encoder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rv_inst_encoder.sv
// RV32I instruction encoder/loader: packs decoded fields into 32-bit words,
// buffers them in a small FIFO and writes them to consecutive memory addresses.
module rv_inst_encoder #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        f3,
  input  logic [6:0]        f7,
  input  logic [31:0]       imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state;
  logic [31:0]   fifo [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] occ;
  logic [PW-1:0] occ_nxt;
  logic [31:0]   enc;
  logic          start_ok;
  logic          fire;
  logic          empty;
  logic          push;
  logic          pop;

  // Field packing per op class
  always_comb begin
    enc = '0;
    case (op)
      3'd0:    enc = {f7, rs2, rs1, f3, rd, 7'b0110011};
      3'd1:    enc = {imm[11:0], rs1, f3, rd, 7'b0010011};
      3'd2:    enc = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      3'd3:    enc = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      3'd4:    enc = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
      3'd5:    enc = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
      3'd6:    enc = {imm[31:12], rd, 7'b0110111};
      default: enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endcase
  end

  // Handshake and occupancy bookkeeping
  always_comb begin
    start_ok = (state == IDLE) && start;
    fire     = mem_we && mem_ready;
    empty    = (wr_ptr == rd_ptr);
    push     = (state == RUN) && in_valid && in_ready;
    pop      = ((state == RUN) || (state == DRAIN)) && !empty && (!mem_we || mem_ready);
    occ      = wr_ptr - rd_ptr;
    occ_nxt  = occ + PW'(push) - PW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr[AW-1:0]] <= enc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (start_ok) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Output stage: mem_addr doubles as the running write address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      mem_addr  <= '0;
      count     <= '0;
    end else begin
      if (start_ok) begin
        mem_addr <= base_addr;
        count    <= '0;
      end else if (fire) begin
        mem_addr <= mem_addr + ADDR_W'(4);
        count    <= count + CNT_W'(1);
      end
      if (pop) begin
        mem_we    <= 1'b1;
        mem_wdata <= fifo[rd_ptr[AW-1:0]];
      end else if (fire) begin
        mem_we    <= 1'b0;
      end
    end
  end

  // Session FSM; in_ready is registered from next-cycle occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            in_ready <= 1'b1;
          end
        end
        RUN: begin
          if (push && in_last) begin
            state    <= DRAIN;
            in_ready <= 1'b0;
          end else begin
            in_ready <= (occ_nxt != PW'(DEPTH));
          end
        end
        DRAIN: begin
          if (empty && !mem_we) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
